// File: rtl/nn_pkg.sv
// Shared NN-datapath definitions: image geometry and the pixel fetch FSM states.
package nn_pkg;
    localparam int PIX_W      = 8;
    localparam int IMG_PIX    = 784;
    localparam int IMG_ADDR_W = 10;
    localparam int IDX_W      = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/pixel_fetch_ctrl_if.sv
// Pixel stream from the fetch controller to the layer-0 neuron array.
interface pixel_fetch_ctrl_if #(
    parameter int DATA_W = nn_pkg::PIX_W
);
    logic                    m_valid;
    logic                    m_ready;
    logic [DATA_W-1:0]       m_data;
    logic [nn_pkg::IDX_W-1:0] m_index;
    logic                    m_last;

    modport master (output m_valid, m_data, m_index, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_index, m_last, output m_ready);
endinterface

// File: rtl/pix_skid_fifo.sv
// Small circular buffer that absorbs ROM read latency under downstream backpressure.
module pix_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 19
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic                         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign dout  = mem[rd_ptr];
    assign empty = (occ == '0);

    // Storage and pointers; flush drops everything, including a same-cycle push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            occ <= occ + OW'(push) - OW'(pop);
        end
    end

    // The upstream credit rule must keep a push from ever landing on a full buffer.
    assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && !flush && occ == OW'(DEPTH)));
endmodule

// File: rtl/pixel_fetch_ctrl.sv
// Fetches one image from block ROM and streams it, in index order, to layer 0.
module pixel_fetch_ctrl
    import nn_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int ADDR_W = IMG_ADDR_W,
    parameter int N_PIX  = IMG_PIX,
    parameter int RD_LAT = 1,
    parameter int BUF_D  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] img_base,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    pixel_fetch_ctrl_if.master pix
);
    localparam int CW = $clog2(N_PIX + 1);
    localparam int OW = $clog2(BUF_D + 1);
    localparam int EW = 1 + IDX_W + DATA_W;
    localparam int FW = $clog2(RD_LAT + BUF_D + 2);

    fetch_state_t      state;
    logic [CW-1:0]     issued, recvd;
    logic [ADDR_W-1:0] base_q;
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT:0]   vld_pipe;
    logic [FW-1:0]     inflight;
    logic [OW-1:0]     occ;
    logic              empty, push, pop, credit_ok, head_last;
    logic [EW-1:0]     din, dout;

    // vld_pipe[k] marks a read issued k cycles ago; the tail lines up with mem_dout.
    assign vld_pipe = {vld_q, mem_en};
    assign push     = vld_pipe[RD_LAT];
    assign pop      = pix.m_valid & pix.m_ready;

    // Reads already issued but not yet landed in the buffer.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < RD_LAT; k++) inflight = inflight + FW'(vld_q[k]);
    end

    // A slot is reserved for every in-flight read, so the buffer cannot overflow.
    assign credit_ok = (inflight + FW'(occ)) < (FW'(BUF_D) + FW'(pop));
    assign mem_en    = (state == FETCH) && !abort && (issued < CW'(N_PIX)) && credit_ok;
    assign mem_addr  = base_q + ADDR_W'(issued);

    assign din = {recvd == CW'(N_PIX - 1), IDX_W'(recvd), mem_dout};

    pix_skid_fifo #(.DEPTH(BUF_D), .W(EW)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (dout),
        .occ   (occ),
        .empty (empty)
    );

    assign {head_last, pix.m_index, pix.m_data} = dout;
    assign pix.m_valid = !empty;
    assign pix.m_last  = !empty && head_last;

    // Sequencing FSM with registered busy/done; abort flushes and returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            issued <= '0;
            recvd  <= '0;
            base_q <= '0;
            vld_q  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (abort) begin
            state  <= IDLE;
            issued <= '0;
            recvd  <= '0;
            vld_q  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            vld_q <= vld_pipe[RD_LAT-1:0];
            done  <= 1'b0;
            if (mem_en) issued <= issued + 1'b1;
            if (push)   recvd  <= recvd + 1'b1;
            case (state)
                IDLE: if (start) begin
                    state  <= FETCH;
                    base_q <= img_base;
                    issued <= '0;
                    recvd  <= '0;
                    busy   <= 1'b1;
                end
                FETCH: if (issued == CW'(N_PIX)) state <= DRAIN;
                DRAIN: if (pop && pix.m_last) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// Bench for pixel_fetch_ctrl: two instances (RD_LAT=1/BUF_D=2 and RD_LAT=3/BUF_D=4) share
// stimulus; a scoreboard of expected beats is filled on start and consumed on each handshake.
module tb_pixel_fetch_ctrl;
    logic       clk, rst, start, abort, m_ready;
    logic [9:0] img_base;
    int         rdy_mode, epoch, cap_base, n_chk, n_err, dn_exp, cyc;
    logic [18:0] exp_q[$];

    logic [1:0]       busy_w, done_w, en_w, vld_w, last_w;
    logic [1:0][9:0]  addr_w;
    logic [1:0][7:0]  data_w;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int RL = (g == 0) ? 1 : 3;
        localparam int BD = (g == 0) ? 2 : 4;

        pixel_fetch_ctrl_if #(.DATA_W(8)) pix ();
        logic       busy, done, mem_en;
        logic [9:0] mem_addr;
        logic [7:0] mem_dout;
        logic [7:0] rom_pipe [RL];

        pixel_fetch_ctrl #(.DATA_W(8), .ADDR_W(10), .N_PIX(784), .RD_LAT(RL), .BUF_D(BD)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .abort    (abort),
            .img_base (img_base),
            .busy     (busy),
            .done     (done),
            .mem_en   (mem_en),
            .mem_addr (mem_addr),
            .mem_dout (mem_dout),
            .pix      (pix)
        );

        assign pix.m_ready = m_ready;
        assign busy_w[g] = busy;
        assign done_w[g] = done;
        assign en_w[g]   = mem_en;
        assign vld_w[g]  = pix.m_valid;
        assign last_w[g] = pix.m_last;
        assign addr_w[g] = mem_addr;
        assign data_w[g] = pix.m_data;

        // ROM model: mem[a] = a[7:0], data appears RL cycles after the enable.
        always @(posedge clk) begin
            if (mem_en) rom_pipe[0] <= mem_addr[7:0];
            for (int k = 1; k < RL; k++) rom_pipe[k] <= rom_pipe[k-1];
        end
        assign mem_dout = rom_pipe[RL-1];

        int rd_ptr, beats, dones, outst, rd_cnt, my_ep, done_due, first_cyc, last_cyc;
        logic hold_v;
        logic [7:0] hold_d;
        logic [9:0] hold_i;
        initial begin
            rd_ptr = 0; beats = 0; dones = 0; outst = 0; rd_cnt = 0; my_ep = 0;
            done_due = 0; first_cyc = 0; last_cyc = 0; hold_v = 0;
        end

        // Monitor: scoreboard, stall stability, credit bound, address sequence, done timing.
        always @(negedge clk) begin
            logic hs;
            logic [18:0] e;
            if (!rst) begin
                outst = 0; rd_cnt = 0; hold_v = 0; done_due = 0;
            end else begin
                if (epoch != my_ep) begin
                    my_ep = epoch; rd_ptr = 0; beats = 0;
                end
                hs = pix.m_valid && pix.m_ready;
                if (hold_v && busy) begin
                    chk("stall_valid", 32'(pix.m_valid), 1);
                    chk("stall_data", 32'(pix.m_data), 32'(hold_d));
                    chk("stall_index", 32'(pix.m_index), 32'(hold_i));
                end
                hold_v = pix.m_valid && !pix.m_ready;
                hold_d = pix.m_data;
                hold_i = pix.m_index;
                if (done_due == 2) begin
                    chk("done_fall", 32'({done, busy}), 0);
                    done_due = 0;
                end
                if (done_due == 1) begin
                    chk("done_pulse", 32'({done, busy}), 3);
                    done_due = 2;
                end
                if (done) dones++;
                if (!busy) begin
                    outst = 0; rd_cnt = 0;
                end else begin
                    if (mem_en) begin
                        chk("mem_addr", 32'(mem_addr), 32'((cap_base + rd_cnt) % 1024));
                        rd_cnt++;
                    end
                    outst = outst + int'(mem_en) - int'(hs);
                    if (mem_en || hs) chk("credit", 32'(outst <= BD), 1);
                end
                if (hs) begin
                    if (rd_ptr < exp_q.size()) begin
                        e = exp_q[rd_ptr];
                        rd_ptr++;
                        chk("beat", 32'({pix.m_last, pix.m_index, pix.m_data}), 32'(e));
                    end else begin
                        chk("extra_beat", 1, 0);
                    end
                    if (beats == 0) first_cyc = cyc;
                    if (pix.m_last) begin
                        last_cyc = cyc;
                        done_due = 1;
                    end
                    beats++;
                end
            end
        end
    end

    // Downstream ready: 0 = stalled, 1 = always ready, 2 = random 50%.
    initial begin
        m_ready = 0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input int base);
        logic [18:0] e;
        img_base = 10'(base);
        cap_base = base;
        exp_q.delete();
        for (int i = 0; i < 784; i++) begin
            e = {i == 783, 10'(i), 8'((base + i) % 1024)};
            exp_q.push_back(e);
        end
        epoch++;
        start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy_w != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 1);
    endtask

    task automatic check_run(input string tag);
        dn_exp++;
        chk({tag, "_beats_a"}, g_dut[0].rd_ptr, 784);
        chk({tag, "_beats_b"}, g_dut[1].rd_ptr, 784);
        chk({tag, "_dones_a"}, g_dut[0].dones, dn_exp);
        chk({tag, "_dones_b"}, g_dut[1].dones, dn_exp);
    endtask

    initial begin
        int la, lb, n;
        n_chk = 0; n_err = 0; dn_exp = 0; epoch = 0; cap_base = 0;
        rst = 0; start = 0; abort = 0; img_base = '0; rdy_mode = 0;
        tick(2);
        chk("rst_busy", 32'(busy_w), 0);
        chk("rst_done", 32'(done_w), 0);
        chk("rst_mem_en", 32'(en_w), 0);
        chk("rst_valid", 32'(vld_w), 0);
        chk("rst_last", 32'(last_w), 0);
        chk("rst_addr", 32'(addr_w), 0);
        chk("rst_data", 32'(data_w), 0);
        rst = 1;
        tick(2);

        // Full-rate run from base 0: latency, throughput, done timing.
        rdy_mode = 1;
        tick(1);
        go(0);
        la = -1; lb = -1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (la < 0 && vld_w[0]) la = c;
            if (lb < 0 && vld_w[1]) lb = c;
        end
        chk("latency_a", 32'(la), 2);
        chk("latency_b", 32'(lb), 4);
        wait_idle(3000);
        chk("rate_a", 32'(g_dut[0].last_cyc - g_dut[0].first_cyc), 783);
        chk("rate_b", 32'(g_dut[1].last_cyc - g_dut[1].first_cyc), 783);
        check_run("t1");
        tick(2);

        // Random backpressure plus a start pulse while busy (must be ignored).
        rdy_mode = 2;
        go(0);
        tick(5);
        img_base = 10'd500;
        start = 1;
        tick(1);
        start = 0;
        wait_idle(8000);
        check_run("t2");
        tick(2);

        // Base near the top of the ROM: address wraps after 1023.
        rdy_mode = 1;
        go(1000);
        wait_idle(3000);
        check_run("t3");
        tick(2);

        // Abort around beat 300 with reads in flight.
        go(0);
        n = 0;
        while (g_dut[0].beats < 300 && n < 2000) begin
            tick(1);
            n++;
        end
        chk("abort_reach", 32'(n < 2000), 1);
        rdy_mode = 0;
        abort = 1;
        tick(1);
        abort = 0;
        exp_q.delete();
        epoch++;
        @(negedge clk);
        chk("abort_valid", 32'(vld_w), 0);
        chk("abort_busy", 32'(busy_w), 0);
        tick(10);
        chk("abort_quiet", 32'(vld_w), 0);
        chk("abort_nodone_a", g_dut[0].dones, dn_exp);
        chk("abort_nodone_b", g_dut[1].dones, dn_exp);
        rdy_mode = 1;
        go(0);
        wait_idle(3000);
        check_run("t4");
        tick(2);

        // start and abort together in IDLE: abort wins.
        img_base = 10'd7;
        start = 1;
        abort = 1;
        tick(1);
        start = 0;
        abort = 0;
        @(negedge clk);
        chk("sa_busy", 32'(busy_w), 0);
        tick(4);
        chk("sa_mem_en", 32'(en_w), 0);
        chk("sa_valid", 32'(vld_w), 0);

        // Asynchronous reset mid-fetch, then a clean run.
        rdy_mode = 2;
        go(0);
        tick(30);
        @(posedge clk);
        #3;
        rst = 0;
        #1;
        chk("arst_busy", 32'(busy_w), 0);
        chk("arst_done", 32'(done_w), 0);
        chk("arst_mem_en", 32'(en_w), 0);
        chk("arst_valid", 32'(vld_w), 0);
        chk("arst_last", 32'(last_w), 0);
        chk("arst_addr", 32'(addr_w), 0);
        chk("arst_data", 32'(data_w), 0);
        exp_q.delete();
        epoch++;
        tick(2);
        rst = 1;
        tick(2);
        go(0);
        wait_idle(8000);
        check_run("t5");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
